// File: rtl/ahb_wait_slave_if.sv
// AHB-lite slave bus bundle for ahb_wait_slave, with master and slave views.
interface ahb_wait_slave_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hready_in;
   logic [7:0]  wait_num;
   logic        hready_out;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
             hready_in, wait_num,
      input  hready_out, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
             hready_in, wait_num,
      output hready_out, hresp, hrdata
   );
endinterface

// File: rtl/ahb_wait_slave.sv
// AHB-lite memory slave with programmable wait states per transfer.
// Define AHB_WAIT_SLAVE_ERR_EN to enable size/alignment ERROR responses.
module ahb_wait_slave #(
   parameter int MEM_AW = 10
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst_b,
   ahb_wait_slave_if.slave  bus,
   output logic [1:0]       dbg_state
);

   localparam int AW = MEM_AW + 2;

`ifdef AHB_WAIT_SLAVE_ERR_EN
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1
   } state_t;
`endif

   state_t          state, state_nx;
   logic [7:0]      cnt, cnt_nx;
   logic            pend, pend_nx;
   logic [AW-1:0]   lat_addr, lat_addr_nx;
   logic            lat_write, lat_write_nx;
   logic [2:0]      lat_size, lat_size_nx;
   logic            accept;
   logic            complete;
   logic            do_write;
   logic            ready_q;
   logic [1:0]      resp_q;
   logic [3:0]      be;
   logic [MEM_AW-1:0] widx;
   logic [31:0]     mem [0:(1<<MEM_AW)-1];
   logic            unused_bits;

   // Handshake: an address phase is taken when hsel && htrans[1] && hready_in
   // are all high on a rising edge; a data phase completes on the edge where
   // hready_out is high, and hready_out only drops while a transfer is owed.
   assign accept   = bus.hsel && bus.htrans[1] && bus.hready_in;
   assign complete = (state == S_IDLE) && pend;
   assign do_write = complete && lat_write;
   assign widx     = lat_addr[AW-1:2];

`ifdef AHB_WAIT_SLAVE_ERR_EN
   logic acc_err;
   assign acc_err = (bus.hsize > 3'd2) ||
                    ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                    ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
`endif

   always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
      if (!cpu_rst_b) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         pend      <= 1'b0;
         lat_addr  <= '0;
         lat_write <= 1'b0;
         lat_size  <= 3'd0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         pend      <= pend_nx;
         lat_addr  <= lat_addr_nx;
         lat_write <= lat_write_nx;
         lat_size  <= lat_size_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      pend_nx      = pend;
      lat_addr_nx  = lat_addr;
      lat_write_nx = lat_write;
      lat_size_nx  = lat_size;
      ready_q      = 1'b1;
      resp_q       = 2'b00;
      case (state)
         S_WAIT: begin
            ready_q = 1'b0;
            cnt_nx  = cnt - 8'd1;
            if (cnt <= 8'd1) state_nx = S_IDLE;
         end
`ifdef AHB_WAIT_SLAVE_ERR_EN
         S_ERR1: begin
            ready_q  = 1'b0;
            resp_q   = 2'b01;
            state_nx = S_ERR2;
         end
`endif
         default: begin
            // IDLE and ERR2 both drive ready high, so either may take a new accept
`ifdef AHB_WAIT_SLAVE_ERR_EN
            if (state == S_ERR2) resp_q = 2'b01;
`endif
            state_nx = S_IDLE;
            pend_nx  = 1'b0;
            if (accept) begin
               lat_addr_nx  = bus.haddr[AW-1:0];
               lat_write_nx = bus.hwrite;
               lat_size_nx  = bus.hsize;
`ifdef AHB_WAIT_SLAVE_ERR_EN
               if (acc_err) state_nx = S_ERR1;
               else
`endif
               begin
                  pend_nx = 1'b1;
                  if (bus.wait_num != 8'd0) begin
                     state_nx = S_WAIT;
                     cnt_nx   = bus.wait_num;
                  end
               end
            end
         end
      endcase
   end

   // Misaligned halves and oversize accesses fall back to a full word
   always_comb begin
      be = 4'hF;
      case (lat_size)
         3'd0:    be = 4'b0001 << lat_addr[1:0];
         3'd1:    if (!lat_addr[0]) be = lat_addr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'hF;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[widx][8*b +: 8] <= bus.hwdata[8*b +: 8];
         end
      end
   end

   assign bus.hready_out = ready_q;
   assign bus.hresp      = resp_q;
   assign bus.hrdata     = (complete && !lat_write) ? mem[widx] : 32'h0;
   assign dbg_state      = state;

   assign unused_bits = &{1'b0, bus.haddr[31:AW], bus.hburst, bus.hprot};

endmodule

// File: tb/tb_ahb_wait_slave.sv
// Directed bench for ahb_wait_slave; honours AHB_WAIT_SLAVE_ERR_EN if defined.
module tb_ahb_wait_slave;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_b = 1'b0;
   logic [1:0]  dbg_state;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   ahb_wait_slave_if bus ();
   assign bus.hready_in = bus.hready_out;

   ahb_wait_slave #(.MEM_AW(10)) dut (
      .cpu_clk   (cpu_clk),
      .cpu_rst_b (cpu_rst_b),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic drive_addr(input logic [31:0] a, input logic w,
                             input logic [2:0] sz, input logic [7:0] wn);
      bus.hsel     = 1'b1;
      bus.htrans   = 2'b10;
      bus.haddr    = a;
      bus.hwrite   = w;
      bus.hsize    = sz;
      bus.wait_num = wn;
   endtask

   task automatic drive_idle();
      bus.hsel   = 1'b0;
      bus.htrans = 2'b00;
      bus.hwrite = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      drive_addr(a, 1'b1, sz, 8'd0);
      tick();
      bus.hwdata = d;
      drive_idle();
      tick();
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      drive_addr(a, 1'b0, 3'd2, 8'd0);
      tick();
      drive_idle();
      d = bus.hrdata;
      tick();
   endtask

   task automatic test_reset();
      cpu_rst_b = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL reset_hready got=%0b want=1", bus.hready_out); end
      n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL reset_hresp got=%0b want=00", bus.hresp); end
      n_cmp++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL reset_hrdata got=%h want=0", bus.hrdata); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
      cpu_rst_b = 1'b1;
      tick();
   endtask

   task automatic test_zero_wait();
      drive_addr(32'h10, 1'b1, 3'd2, 8'd0);
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL zw_aphase_ready got=%0b want=1", bus.hready_out); end
      tick();
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL zw_wdata_ready got=%0b want=1", bus.hready_out); end
      bus.hwdata = 32'hDEADBEEF;
      drive_addr(32'h10, 1'b0, 3'd2, 8'd0);
      tick();
      drive_idle();
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL zw_rdata_ready got=%0b want=1", bus.hready_out); end
      n_cmp++; if (bus.hrdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL zw_rdata got=%h want=deadbeef", bus.hrdata); end
      n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL zw_hresp got=%0b want=00", bus.hresp); end
      tick();
      n_cmp++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL zw_rdata_idle got=%h want=0", bus.hrdata); end
   endtask

   task automatic test_wait_states();
      int lows;
      wr(32'h20, 3'd2, 32'h12345678);
      drive_addr(32'h20, 1'b0, 3'd2, 8'd3);
      tick();
      drive_idle();
      bus.wait_num = 8'd7;
      lows = 0;
      while (bus.hready_out === 1'b0 && lows < 20) begin
         n_cmp++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL ws_rdata_during_wait got=%h want=0", bus.hrdata); end
         lows++;
         tick();
      end
      n_cmp++; if (lows != 3) begin n_err++; $display("FAIL ws_low_cycles got=%0d want=3", lows); end
      n_cmp++; if (bus.hrdata !== 32'h12345678) begin n_err++; $display("FAIL ws_rdata got=%h want=12345678", bus.hrdata); end
      n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL ws_hresp got=%0b want=00", bus.hresp); end
      tick();
      n_cmp++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL ws_rdata_after got=%h want=0", bus.hrdata); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d;
      wr(32'h10, 3'd2, 32'h11223344);
      wr(32'h13, 3'd0, 32'hAAAAAAAA);
      rd(32'h10, d);
      n_cmp++; if (d !== 32'hAA223344) begin n_err++; $display("FAIL bl_byte3 got=%h want=aa223344", d); end
      wr(32'h12, 3'd1, 32'hBEEFBEEF);
      rd(32'h10, d);
      n_cmp++; if (d !== 32'hBEEF3344) begin n_err++; $display("FAIL bl_half_hi got=%h want=beef3344", d); end
      wr(32'h10, 3'd0, 32'h55555555);
      rd(32'h10, d);
      n_cmp++; if (d !== 32'hBEEF3355) begin n_err++; $display("FAIL bl_byte0 got=%h want=beef3355", d); end
   endtask

   task automatic test_idle_busy();
      logic [31:0] d;
      bus.hsel   = 1'b1;
      bus.htrans = 2'b01;
      bus.haddr  = 32'h10;
      bus.hwrite = 1'b1;
      bus.hwdata = 32'h0;
      tick();
      bus.htrans = 2'b00;
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL ib_busy_ready got=%0b want=1", bus.hready_out); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL ib_busy_state got=%0d want=0", dbg_state); end
      tick();
      drive_idle();
      n_cmp++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL ib_idle_rdata got=%h want=0", bus.hrdata); end
      tick();
      rd(32'h10, d);
      n_cmp++; if (d !== 32'hBEEF3355) begin n_err++; $display("FAIL ib_mem_kept got=%h want=beef3355", d); end
   endtask

   task automatic test_error();
      wr(32'h00, 3'd2, 32'hCAFEF00D);
`ifdef AHB_WAIT_SLAVE_ERR_EN
      drive_addr(32'h02, 1'b0, 3'd2, 8'd0);
      tick();
      drive_idle();
      n_cmp++; if (bus.hready_out !== 1'b0) begin n_err++; $display("FAIL er_c1_ready got=%0b want=0", bus.hready_out); end
      n_cmp++; if (bus.hresp !== 2'b01) begin n_err++; $display("FAIL er_c1_hresp got=%0b want=01", bus.hresp); end
      tick();
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL er_c2_ready got=%0b want=1", bus.hready_out); end
      n_cmp++; if (bus.hresp !== 2'b01) begin n_err++; $display("FAIL er_c2_hresp got=%0b want=01", bus.hresp); end
      tick();
      n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL er_after_hresp got=%0b want=00", bus.hresp); end
      // misaligned half write, then a read accepted during ERR2
      drive_addr(32'h01, 1'b1, 3'd1, 8'd0);
      tick();
      drive_idle();
      bus.hwdata = 32'hFFFFFFFF;
      tick();
      n_cmp++; if (bus.hresp !== 2'b01 || bus.hready_out !== 1'b1) begin n_err++; $display("FAIL er_w_err2 got=%0b/%0b want=01/1", bus.hresp, bus.hready_out); end
      drive_addr(32'h00, 1'b0, 3'd2, 8'd0);
      tick();
      drive_idle();
      n_cmp++; if (bus.hrdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL er_array_kept got=%h want=cafef00d", bus.hrdata); end
      n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL er_read_hresp got=%0b want=00", bus.hresp); end
      tick();
`else
      drive_addr(32'h02, 1'b0, 3'd2, 8'd0);
      tick();
      drive_idle();
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL ne_ready got=%0b want=1", bus.hready_out); end
      n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL ne_hresp got=%0b want=00", bus.hresp); end
      n_cmp++; if (bus.hrdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL ne_rdata got=%h want=cafef00d", bus.hrdata); end
      tick();
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      logic [31:0] wdat [3];
      logic [31:0] d;
      logic [31:0] e;
      int lows;
      addrs = '{32'h0, 32'h4, 32'h8};
      wdat  = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
      wr(32'h8, 3'd2, 32'h55555555);
      drive_addr(addrs[0], 1'b1, 3'd2, 8'd2);
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.hwdata = wdat[i];
         if (i < 2) drive_addr(addrs[i+1], 1'b1, 3'd2, 8'd0);
         else drive_idle();
         if (i == 2) break;
         lows = 0;
         while (bus.hready_out === 1'b0 && lows < 10) begin
            lows++;
            tick();
         end
         n_cmp++; if (lows != 2) begin n_err++; $display("FAIL b2b_wait%0d got=%0d want=2", i, lows); end
         n_cmp++; if (bus.hresp !== 2'b00) begin n_err++; $display("FAIL b2b_hresp%0d got=%0b want=00", i, bus.hresp); end
         bus.wait_num = 8'd2;
         tick();
      end
      n_cmp++; if (bus.hready_out !== 1'b0) begin n_err++; $display("FAIL b2b_t3_w1 got=%0b want=0", bus.hready_out); end
      tick();
      n_cmp++; if (bus.hready_out !== 1'b0 || dbg_state !== 2'd1) begin n_err++; $display("FAIL b2b_t3_w2 got=%0b/%0d want=0/1", bus.hready_out, dbg_state); end
      cpu_rst_b = 1'b0;
      #1;
      n_cmp++; if (bus.hready_out !== 1'b1) begin n_err++; $display("FAIL b2b_rst_ready got=%0b want=1", bus.hready_out); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL b2b_rst_state got=%0d want=0", dbg_state); end
      tick();
      cpu_rst_b = 1'b1;
      tick();
      exp_q.push_back(32'hA0A0A0A0);
      exp_q.push_back(32'hB1B1B1B1);
      exp_q.push_back(32'h55555555);
      for (int i = 0; i < 3; i++) begin
         rd(addrs[i], d);
         e = exp_q.pop_front();
         n_cmp++; if (d !== e) begin n_err++; $display("FAIL b2b_readback%0d got=%h want=%h", i, d, e); end
      end
   endtask

   initial begin
      bus.hsel     = 1'b0;
      bus.haddr    = 32'h0;
      bus.htrans   = 2'b00;
      bus.hwrite   = 1'b0;
      bus.hsize    = 3'd2;
      bus.hburst   = 3'd0;
      bus.hprot    = 4'd0;
      bus.hwdata   = 32'h0;
      bus.wait_num = 8'd0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_byte_lanes();
      test_idle_busy();
      test_error();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
